// File: rtl/mps_sys_fsm.sv
// MPS controller top-level operating-mode FSM.
// Sequences power-on/off enables and handles interlock recovery.
module mps_sys_fsm #(
    parameter logic [3:0] ON_DONE_ST   = 4'd14,
    parameter logic [3:0] OFF_DONE_ST  = 4'd6,
    parameter logic [3:0] SEQ_FAULT_ST = 4'd15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_op_on,
    input  logic       i_op_man_stop,
    input  logic       i_run,
    input  logic       i_ready,
    input  logic       i_op_off,
    input  logic [3:0] i_op_on_fsm,
    input  logic [3:0] i_op_off_fsm,
    input  logic       i_op_mode,
    input  logic       i_intl_flag,
    output logic       o_op_on_flag,
    output logic       o_op_off_flag,
    output logic [2:0] o_sys_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ON_SEQ  = 3'd1,
        READY   = 3'd2,
        RUN     = 3'd3,
        OFF_SEQ = 3'd4,
        INTL    = 3'd5
    } state_e;

    state_e state_q;
    state_e state_d;

    // Commands only count in remote mode; status inputs always count.
    logic remote;
    logic cmd_on;
    logic cmd_stop;
    logic cmd_run;
    logic cmd_ready;
    logic cmd_off;
    logic on_done;
    logic on_fault;
    logic off_done;
    logic off_fault;

    assign remote    = ~i_op_mode;
    assign cmd_on    = remote & i_op_on;
    assign cmd_stop  = remote & i_op_man_stop;
    assign cmd_run   = remote & i_run;
    assign cmd_ready = remote & i_ready;
    assign cmd_off   = remote & i_op_off;
    assign on_done   = (i_op_on_fsm == ON_DONE_ST);
    assign on_fault  = (i_op_on_fsm == SEQ_FAULT_ST);
    assign off_done  = (i_op_off_fsm == OFF_DONE_ST);
    assign off_fault = (i_op_off_fsm == SEQ_FAULT_ST);

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: interlock > fault > manual stop > done > command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_on) begin
                    state_d = ON_SEQ;
                end
            end
            ON_SEQ: begin
                if (i_intl_flag) begin
                    state_d = INTL;
                end else if (on_fault) begin
                    state_d = INTL;
                end else if (cmd_stop) begin
                    state_d = OFF_SEQ;
                end else if (on_done) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (i_intl_flag) begin
                    state_d = INTL;
                end else if (cmd_stop) begin
                    state_d = OFF_SEQ;
                end else if (cmd_run) begin
                    state_d = RUN;
                end else if (cmd_off) begin
                    state_d = OFF_SEQ;
                end
            end
            RUN: begin
                if (i_intl_flag) begin
                    state_d = INTL;
                end else if (cmd_stop) begin
                    state_d = OFF_SEQ;
                end else if (cmd_ready) begin
                    state_d = READY;
                end
            end
            OFF_SEQ: begin
                if (i_intl_flag) begin
                    state_d = INTL;
                end else if (off_fault) begin
                    state_d = INTL;
                end else if (off_done) begin
                    state_d = IDLE;
                end
            end
            INTL: begin
                if (!i_intl_flag && cmd_ready) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state.
    always_comb begin
        o_op_on_flag  = (state_q == ON_SEQ);
        o_op_off_flag = (state_q == OFF_SEQ);
        o_sys_state   = state_q;
    end

endmodule

// File: tb/tb_mps_sys_fsm.sv
// Directed, table-driven bench for mps_sys_fsm.
// Vectors hold inputs plus hand-computed state and flags.
module tb_mps_sys_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_on, man_stop, run, ready, op_off;
    logic [3:0] on_fsm, off_fsm;
    logic       mode, intl;
    logic       on_flag, off_flag;
    logic [2:0] sys_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mps_sys_fsm dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_op_on       (op_on),
        .i_op_man_stop (man_stop),
        .i_run         (run),
        .i_ready       (ready),
        .i_op_off      (op_off),
        .i_op_on_fsm   (on_fsm),
        .i_op_off_fsm  (off_fsm),
        .i_op_mode     (mode),
        .i_intl_flag   (intl),
        .o_op_on_flag  (on_flag),
        .o_op_off_flag (off_flag),
        .o_sys_state   (sys_state)
    );

    // cmd bits: {op_on, man_stop, run, ready, op_off}
    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] ON = 5'b10000;
    localparam logic [4:0] MS = 5'b01000;
    localparam logic [4:0] RN = 5'b00100;
    localparam logic [4:0] RD = 5'b00010;
    localparam logic [4:0] OF = 5'b00001;

    typedef struct {
        logic       rst;
        logic [4:0] cmd;
        logic [3:0] on_fsm;
        logic [3:0] off_fsm;
        logic       mode;
        logic       intl;
        logic [2:0] st;
        logic       onf;
        logic       offf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic r, logic [4:0] c, logic [3:0] nf,
                               logic [3:0] ff, logic m, logic il,
                               logic [2:0] s, logic a, logic b);
        vec_t t;
        t.rst = r; t.cmd = c; t.on_fsm = nf; t.off_fsm = ff;
        t.mode = m; t.intl = il; t.st = s; t.onf = a; t.offf = b;
        return t;
    endfunction

    task automatic drive(logic r, logic [4:0] c, logic [3:0] nf,
                         logic [3:0] ff, logic m, logic il);
        rst = r;
        {op_on, man_stop, run, ready, op_off} = c;
        on_fsm = nf; off_fsm = ff; mode = m; intl = il;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [2:0] s, logic a, logic b);
        checks++;
        if ({sys_state, on_flag, off_flag} !== {s, a, b}) begin
            errors++;
            $display("FAIL %s: got state=%0d on=%0b off=%0b, want state=%0d on=%0b off=%0b",
                     name, sys_state, on_flag, off_flag, s, a, b);
        end
    endtask

    initial begin
        // rst, cmd, on_fsm, off_fsm, mode, intl -> state, on, off
        vq.push_back(v(1, N,  0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(1, ON, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(v(0, N,  0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, ON, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(v(0, N,  0, 0, 0, 0, 1, 1, 0));
        vq.push_back(v(0, N, 14, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(v(0, OF, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(v(0, N,  0, 0, 0, 1, 5, 0, 0));
        vq.push_back(v(0, OF, 0, 0, 0, 0, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 1, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, OF, 0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 6, 0, 0, 0, 0, 0));
        vq.push_back(v(0, ON, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, N,  0, 0, 0, 1, 0, 0, 0));
        vq.push_back(v(0, ON, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(v(0, N, 15, 0, 0, 0, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 0, 1, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, MS, 0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 0, 0, 1, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(v(0, MS, 0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 15, 0, 0, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 1, 0, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 1, 0, 2, 0, 0));
        vq.push_back(v(0, N,  0, 0, 1, 1, 5, 0, 0));
        vq.push_back(v(0, RD, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(v(0, OF, 0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(1, N,  0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, ON, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(v(0, MS, 14, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 6, 0, 0, 0, 0, 0));
        vq.push_back(v(0, ON, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(v(0, N, 14, 0, 1, 0, 2, 0, 0));
        vq.push_back(v(0, RN, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(v(0, MS|RD, 0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 0, 0, 0, 4, 0, 1));
        vq.push_back(v(0, N,  0, 6, 1, 0, 0, 0, 0));

        rst = 1'b1;
        {op_on, man_stop, run, ready, op_off} = N;
        on_fsm = 0; off_fsm = 0; mode = 0; intl = 0;

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].cmd, vq[i].on_fsm, vq[i].off_fsm,
                  vq[i].mode, vq[i].intl);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].onf, vq[i].offf);
        end

        // Held interlock level keeps INTL until it drops and ready arrives.
        drive(0, ON, 0, 0, 0, 0);
        check("seq_on", 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, RD, 0, 0, 0, 1);
            check($sformatf("intl_hold%0d", k), 5, 0, 0);
        end
        drive(0, N, 0, 0, 0, 0);
        check("intl_dropped", 5, 0, 0);
        drive(0, RD, 0, 0, 0, 0);
        check("intl_clear", 2, 0, 0);

        // Interlock beats sequencer completion on the same edge.
        drive(0, OF, 0, 0, 0, 0);
        check("seq_off", 4, 0, 1);
        drive(0, N, 0, 6, 0, 1);
        check("intl_over_done", 5, 0, 0);

        // Reset mid on-sequence drops flag on the reset edge.
        drive(0, RD, 0, 0, 0, 0);
        drive(0, N, 0, 0, 0, 0);
        drive(1, N, 0, 0, 0, 0);
        check("rst_from_ready", 0, 0, 0);
        drive(0, ON, 0, 0, 0, 0);
        drive(1, ON, 0, 0, 0, 0);
        check("rst_mid_on", 0, 0, 0);
        drive(0, N, 0, 0, 0, 0);
        check("idle_after_rst", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
